// File: rtl/dict_loader.sv
// dict_loader: streams the dictionary image from memory into dict1/2/3 after a start request,
// and passes controller refill traffic straight through to memory while idle.
module dict_loader #(
    parameter int FIELD1_VAL_WIDTH = 7,
    parameter int FIELD2_VAL_WIDTH = 12,
    parameter int FIELD3_VAL_WIDTH = 13,
    parameter int FIELD1_ENTRIES = 8,
    parameter int FIELD2_ENTRIES = 64,
    parameter int FIELD3_ENTRIES = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        loaded,
    input  logic                        ctrl_mem_req_valid,
    output logic                        ctrl_mem_req_ready,
    input  logic [31:0]                 ctrl_mem_req_addr,
    output logic [31:0]                 ctrl_mem_req_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_addr,
    input  logic [31:0]                 mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);
    localparam int TOTAL = FIELD1_ENTRIES + FIELD2_ENTRIES + FIELD3_ENTRIES;
    localparam int IW = TOTAL > 1 ? $clog2(TOTAL) : 1;
    localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);
    localparam logic [IW-1:0] END1 = IW'(FIELD1_ENTRIES);
    localparam logic [IW-1:0] END2 = IW'(FIELD1_ENTRIES + FIELD2_ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_WRITE} state_t;

    state_t        state;
    logic          pending;
    logic [IW-1:0] idx;

    // busy spans exactly REQ and WRITE, so it also selects the memory port owner
    assign mem_req_valid      = busy ? state == S_REQ : ctrl_mem_req_valid;
    assign mem_req_addr       = busy ? BASE_ADDR + (32'(idx) << 2) : ctrl_mem_req_addr;
    assign ctrl_mem_req_ready = busy ? 1'b0 : mem_req_ready;
    assign ctrl_mem_req_rdata = busy ? '0 : mem_req_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            pending            <= 1'b0;
            idx                <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            loaded             <= 1'b0;
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_val    <= '0;
            dict3_write_val    <= '0;
        end else begin
            done               <= 1'b0;
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        state   <= S_WAIT;
                        pending <= 1'b0;
                    end else if (start) begin
                        pending <= 1'b1;
                    end
                end
                // never split an in-flight controller transaction
                S_WAIT: begin
                    if (!ctrl_mem_req_valid) begin
                        state  <= S_REQ;
                        idx    <= '0;
                        loaded <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state <= S_WRITE;
                        if (idx < END1) begin
                            dict1_write_enable <= 1'b1;
                            dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                        end else if (idx < END2) begin
                            dict2_write_enable <= 1'b1;
                            dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                        end else begin
                            dict3_write_enable <= 1'b1;
                            dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                        end
                    end
                end
                S_WRITE: begin
                    if (idx == LAST) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        loaded <= 1'b1;
                    end else begin
                        state <= S_REQ;
                        idx   <= idx + IW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dict_loader.sv
// tb_dict_loader: directed bench for dict_loader with a behavioural memory and controller.
module tb_dict_loader;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk, reset, start;
    logic        busy, done, loaded;
    logic        ctrl_mem_req_valid, ctrl_mem_req_ready;
    logic [31:0] ctrl_mem_req_addr, ctrl_mem_req_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_rdata;
    logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
    logic [6:0]  dict1_write_val;
    logic [11:0] dict2_write_val;
    logic [12:0] dict3_write_val;

    dict_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .loaded(loaded),
        .ctrl_mem_req_valid(ctrl_mem_req_valid), .ctrl_mem_req_ready(ctrl_mem_req_ready),
        .ctrl_mem_req_addr(ctrl_mem_req_addr), .ctrl_mem_req_rdata(ctrl_mem_req_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
        .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
        .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
        .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val)
    );

    int total = 0, bad = 0;
    int cyc = 0, lat = 2, cnt = 0;
    logic big0 = 1'b0;
    logic [31:0] wq[$], aq[$];
    int req_seen, req_cyc, done_cnt, done_cyc, busy_cyc, stall_viol, multi;
    logic busy_at_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] i = (a - BASE) >> 2;
        if (a >= BASE && i < 200) return (i == 0 && big0) ? 32'hFFFF_FF85 : i;
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] wat(input int i);
        return i < wq.size() ? wq[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] aat(input int i);
        return i < aq.size() ? aq[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic clear();
        wq.delete();
        aq.delete();
        req_seen = 0; req_cyc = 0; done_cnt = 0; done_cyc = 0;
        busy_cyc = 0; stall_viol = 0; multi = 0; busy_at_done = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_nwr(input int n, input int limit);
        for (int i = 0; i < limit && wq.size() < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory: ready strobe on the lat-th consecutive valid cycle
    initial begin
        mem_req_ready = 1'b0;
        mem_req_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                cnt = 0;
            end else if (mem_req_valid) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_req_ready = 1'b1;
                    mem_req_rdata = mem_word(mem_req_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (dict1_write_enable) wq.push_back({16'd1, 16'(dict1_write_val)});
        if (dict2_write_enable) wq.push_back({16'd2, 16'(dict2_write_val)});
        if (dict3_write_enable) wq.push_back({16'd3, 16'(dict3_write_val)});
        if (int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable) > 1) multi++;
        if (mem_req_valid && mem_req_ready && busy) aq.push_back(mem_req_addr);
        if (mem_req_valid && busy && req_seen == 0) begin
            req_seen = 1;
            req_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (busy) busy_cyc++;
        if (ctrl_mem_req_ready && busy) stall_viol++;
    end

    initial begin
        int err, aerr, waitbusy, rcyc;
        logic [31:0] exp;
        reset = 1'b1;
        start = 1'b0;
        ctrl_mem_req_valid = 1'b0;
        ctrl_mem_req_addr = 32'h1234_5678;
        clear();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_loaded", 32'(loaded), 0);
        chk("rst_we", 32'({dict1_write_enable, dict2_write_enable, dict3_write_enable}), 0);
        chk("rst_vals", 32'({dict1_write_val, dict2_write_val, dict3_write_val}), 0);
        chk("rst_mvalid", 32'(mem_req_valid), 0);
        chk("rst_maddr", mem_req_addr, 32'h1234_5678);
        reset = 1'b0;

        // start while a slow controller read is in flight
        @(posedge clk); #1;
        lat = 4;
        ctrl_mem_req_valid = 1'b1;
        ctrl_mem_req_addr = 32'h0000_4000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        waitbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waitbusy += int'(busy);
            if (ctrl_mem_req_ready) break;
        end
        chk("inf_ready", 32'(ctrl_mem_req_ready), 1);
        chk("inf_rdata", ctrl_mem_req_rdata, 32'h0000_4000 ^ 32'hDEAD_0000);
        chk("inf_addr", mem_req_addr, 32'h0000_4000);
        chk("inf_busy", 32'(waitbusy), 0);
        @(posedge clk); #1;
        ctrl_mem_req_valid = 1'b0;
        lat = 2;
        wait_done(2000);
        chk("l1_nwr", 32'(wq.size()), 200);
        err = 0;
        for (int i = 0; i < 200; i++) begin
            exp = {16'(i < 8 ? 1 : i < 72 ? 2 : 3), 16'(i)};
            if (wat(i) !== exp) err++;
        end
        chk("l1_order", 32'(err), 0);
        chk("l1_w7", wat(7), {16'd1, 16'd7});
        chk("l1_w8", wat(8), {16'd2, 16'd8});
        chk("l1_w71", wat(71), {16'd2, 16'd71});
        chk("l1_w72", wat(72), {16'd3, 16'd72});
        chk("l1_w199", wat(199), {16'd3, 16'd199});
        chk("l1_naddr", 32'(aq.size()), 200);
        aerr = 0;
        for (int i = 0; i < 200; i++) if (aat(i) !== BASE + 32'(4 * i)) aerr++;
        chk("l1_addrs", 32'(aerr), 0);
        chk("l1_a0", aat(0), 32'h0001_0000);
        chk("l1_a199", aat(199), 32'h0001_031C);
        chk("l1_done_lat", 32'(done_cyc - req_cyc), 600);
        chk("l1_done_cnt", 32'(done_cnt), 1);
        chk("l1_busy_done", 32'(busy_at_done), 0);
        chk("l1_loaded", 32'(loaded), 1);
        chk("l1_multi", 32'(multi), 0);

        // controller request made at entry 50 stalls until the load ends
        clear();
        pulse_start();
        wait_nwr(50, 1000);
        @(posedge clk); #1;
        ctrl_mem_req_valid = 1'b1;
        ctrl_mem_req_addr = 32'h0000_8888;
        wait_done(2000);
        rcyc = 0;
        for (int i = 0; i < 20 && !ctrl_mem_req_ready; i++) @(negedge clk);
        rcyc = cyc;
        chk("l2_nwr", 32'(wq.size()), 200);
        chk("l2_stall", 32'(stall_viol), 0);
        chk("l2_srv_ready", 32'(ctrl_mem_req_ready), 1);
        chk("l2_srv_rdata", ctrl_mem_req_rdata, 32'h0000_8888 ^ 32'hDEAD_0000);
        chk("l2_srv_addr", mem_req_addr, 32'h0000_8888);
        chk("l2_after_done", 32'(rcyc > done_cyc), 1);
        @(posedge clk); #1 ctrl_mem_req_valid = 1'b0;

        // reset at entry 70
        clear();
        pulse_start();
        wait_nwr(70, 1000);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("r70_busy", 32'(busy), 0);
        chk("r70_loaded", 32'(loaded), 0);
        chk("r70_we", 32'({dict1_write_enable, dict2_write_enable, dict3_write_enable}), 0);
        chk("r70_val2", 32'(dict2_write_val), 0);
        chk("r70_mvalid", 32'(mem_req_valid), 0);
        @(negedge clk) reset = 1'b0;

        // wide word 0, and a start during busy must not retrigger
        big0 = 1'b1;
        clear();
        pulse_start();
        wait_nwr(10, 1000);
        pulse_start();
        wait_done(2000);
        chk("l4_w0", wat(0), {16'd1, 16'h0005});
        chk("l4_a0", aat(0), 32'h0001_0000);
        chk("l4_nwr", 32'(wq.size()), 200);
        chk("l4_done_cnt", 32'(done_cnt), 1);
        busy_cyc = 0;
        repeat (30) @(negedge clk);
        #1;
        chk("l4_no_reload", 32'(busy_cyc), 0);
        chk("l4_loaded", 32'(loaded), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
